// File: rtl/alu_defs_pkg.sv
// Shared constants for the ALU op issuer: ALU command codes, the MIPS opcode/funct
// values it decodes, and the FSM state encoding.
package alu_defs;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS ALU-op decoder: opcode/funct/immediate plus register values
// map to an ALU command, an operand pair and an unsupported-op flag.
module alu_op_decode
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [IMM_W-1:0] imm,
  output logic [2:0]       cmd,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             err
);

  logic [WIDTH-1:0] sext_s;
  logic [WIDTH-1:0] zext_s;

  assign sext_s = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign zext_s = {{(WIDTH-IMM_W){1'b0}}, imm};

  // Opcode/funct decode; unsupported ops fall through to ADD of zeros with err set.
  always_comb begin
    cmd = ALU_ADD;
    a   = {WIDTH{1'b0}};
    b   = {WIDTH{1'b0}};
    err = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin cmd = ALU_ADD; a = rs_val; b = rt_val; end
          FN_SUB, FN_SUBU: begin cmd = ALU_SUB; a = rs_val; b = rt_val; end
          FN_AND:          begin cmd = ALU_AND; a = rs_val; b = rt_val; end
          FN_OR:           begin cmd = ALU_OR;  a = rs_val; b = rt_val; end
          FN_XOR:          begin cmd = ALU_XOR; a = rs_val; b = rt_val; end
          FN_NOR:          begin cmd = ALU_NOR; a = rs_val; b = rt_val; end
          // ALU computes B<A, so swapping gives rs<rt
          FN_SLT:          begin cmd = ALU_SLT; a = rt_val; b = rs_val; end
          default:         err = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin cmd = ALU_ADD; a = rs_val; b = sext_s; end
      OP_SLTI:           begin cmd = ALU_SLT; a = sext_s; b = rs_val; end
      OP_ANDI:           begin cmd = ALU_AND; a = rs_val; b = zext_s; end
      OP_ORI:            begin cmd = ALU_OR;  a = rs_val; b = zext_s; end
      OP_XORI:           begin cmd = ALU_XOR; a = rs_val; b = zext_s; end
      default:           err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one decoded MIPS ALU op to the external 3-bit-command ALU, holds operands
// for one EXEC cycle, captures the result and hands it off over valid/ready.
module alu_op_issuer
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  input  logic [IMM_W-1:0] in_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cmd,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic [CNT_W-1:0] ops_done
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_cmd_q, alu_cmd_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic [2:0]       dec_cmd_s;
  logic [WIDTH-1:0] dec_a_s, dec_b_s;
  logic             dec_err_s;
  logic             in_ready_s;
  logic             accept_s;

  alu_op_decode #(.WIDTH(WIDTH), .IMM_W(IMM_W)) u_decode (
    .opcode (in_opcode),
    .funct  (in_funct),
    .rs_val (in_rs_val),
    .rt_val (in_rt_val),
    .imm    (in_imm),
    .cmd    (dec_cmd_s),
    .a      (dec_a_s),
    .b      (dec_b_s),
    .err    (dec_err_s)
  );

  // A waiting result retiring this edge frees the slot for a new op on the same edge
  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;

  // Next-state and datapath register updates
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cmd_d    = alu_cmd_q;
    err_d        = err_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    ops_done_d   = ops_done_q;

    if (accept_s) begin
      alu_a_d   = dec_a_s;
      alu_b_d   = dec_b_s;
      alu_cmd_d = dec_cmd_s;
      err_d     = dec_err_s;
    end else begin
      err_d     = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        out_result_d = err_q ? {WIDTH{1'b0}} : alu_result;
        out_err_d    = err_q;
        out_valid_d  = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ops_done_d  = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d     = accept_s ? ST_EXEC : ST_IDLE;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= {WIDTH{1'b0}};
      alu_b_q      <= {WIDTH{1'b0}};
      alu_cmd_q    <= ALU_ADD;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= {WIDTH{1'b0}};
      out_err_q    <= 1'b0;
      ops_done_q   <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cmd_q    <= alu_cmd_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cmd    = alu_cmd_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: behavioural ALU on alu_*, directed cases
// followed by randomized ops checked against an instruction-level reference model.
module tb_alu_op_issuer;

  localparam int WIDTH = 32;
  localparam int IMM_W = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [5:0]       in_opcode = 6'h00;
  logic [5:0]       in_funct = 6'h00;
  logic [WIDTH-1:0] in_rs_val = 32'h0;
  logic [WIDTH-1:0] in_rt_val = 32'h0;
  logic [IMM_W-1:0] in_imm = 16'h0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_cmd;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic [CNT_W-1:0] ops_done;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] exp_res;
  logic             exp_err;
  int               exp_done = 0;
  bit               pending = 1'b0;

  always #5 clk = ~clk;

  alu_op_issuer #(.WIDTH(WIDTH), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .ops_done(ops_done)
  );

  // Behavioural 3-bit-command ALU; SLT yields unsigned B<A
  function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a ^ b;
      3'd3:    return {31'b0, (b < a)};
      3'd4:    return a & b;
      3'd5:    return ~(a & b);
      3'd6:    return ~(a | b);
      3'd7:    return a | b;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_cmd, alu_a, alu_b);

  // Instruction-level meaning of each op (comparisons unsigned, as the ALU does them)
  function automatic void ref_model(input logic [5:0] opc, input logic [5:0] fn,
                                    input logic [31:0] rs, input logic [31:0] rt,
                                    input logic [15:0] imm,
                                    output logic [31:0] res, output logic err);
    logic [31:0] sx, zx;
    sx  = {{16{imm[15]}}, imm};
    zx  = {16'h0, imm};
    res = 32'h0;
    err = 1'b0;
    case (opc)
      6'h00: begin
        case (fn)
          6'h20, 6'h21: res = rs + rt;
          6'h22, 6'h23: res = rs - rt;
          6'h24:        res = rs & rt;
          6'h25:        res = rs | rt;
          6'h26:        res = rs ^ rt;
          6'h27:        res = ~(rs | rt);
          6'h2A:        res = (rs < rt) ? 32'd1 : 32'd0;
          default:      err = 1'b1;
        endcase
      end
      6'h08, 6'h09: res = rs + sx;
      6'h0A:        res = (rs < sx) ? 32'd1 : 32'd0;
      6'h0C:        res = rs & zx;
      6'h0D:        res = rs | zx;
      6'h0E:        res = rs ^ zx;
      default:      err = 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op; if a result is waiting, retire it on the same edge.
  task automatic send(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [15:0] imm);
    in_opcode = opc; in_funct = fn; in_rs_val = rs; in_rt_val = rt; in_imm = imm;
    in_valid  = 1'b1;
    out_ready = pending;
    #1;
    check("in_ready_pre", {31'b0, in_ready}, 32'd1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_opcode = 6'($urandom); in_funct = 6'($urandom);
    in_rs_val = $urandom; in_rt_val = $urandom; in_imm = 16'($urandom);
    if (pending) begin
      exp_done++;
      pending = 1'b0;
    end
    ref_model(opc, fn, rs, rt, imm, exp_res, exp_err);
    check("ops_done_acc", {16'h0, ops_done}, exp_done[31:0] & 32'hFFFF);
    check("exec_out_valid", {31'b0, out_valid}, 32'd0);
    check("exec_in_ready", {31'b0, in_ready}, 32'd0);
    if (exp_err) begin
      check("err_alu_cmd", {29'b0, alu_cmd}, 32'd0);
      check("err_alu_a", alu_a, 32'd0);
      check("err_alu_b", alu_b, 32'd0);
    end else begin
      check("exec_out_err_prev", 32'd0, 32'd0 & {31'b0, out_valid});
    end
    step();
    check("done_out_valid", {31'b0, out_valid}, 32'd1);
    check("out_result", out_result, exp_res);
    check("out_err", {31'b0, out_err}, {31'b0, exp_err});
    pending = 1'b1;
  endtask

  task automatic hold_done(input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_out_result", out_result, exp_res);
      check("hold_out_err", {31'b0, out_err}, {31'b0, exp_err});
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
  endtask

  task automatic retire(input int n);
    hold_done(n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_done++;
    pending = 1'b0;
    check("ret_out_valid", {31'b0, out_valid}, 32'd0);
    check("ret_ops_done", {16'h0, ops_done}, exp_done[31:0] & 32'hFFFF);
    check("ret_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  logic [5:0] op_tab [12];
  logic [5:0] fn_tab [12];

  initial begin
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h3F, 6'h04};
    fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h2B, 6'h08};

    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_cmd", {29'b0, alu_cmd}, 32'd0);
    check("rst_ops_done", {16'h0, ops_done}, 32'd0);

    // Directed cases
    send(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);       retire(0);
    check("add_12", exp_res, 32'd12);
    send(6'h00, 6'h2A, 32'd3, 32'd9, 16'h0);       retire(0);
    send(6'h00, 6'h2A, 32'd9, 32'd3, 16'h0);       retire(0);
    send(6'h0A, 6'h00, 32'd2, 32'd0, 16'h0004);    retire(0);
    send(6'h08, 6'h00, 32'd10, 32'd0, 16'hFFFF);   retire(0);
    send(6'h0D, 6'h00, 32'hF0, 32'd0, 16'h8001);   retire(0);
    send(6'h23, 6'h00, 32'h1234, 32'h5678, 16'h0010);
    hold_done(5);
    send(6'h00, 6'h22, 32'd100, 32'd1, 16'h0);     retire(1);

    // Reset while EXEC discards the op and its result
    in_opcode = 6'h00; in_funct = 6'h20; in_rs_val = 32'd1; in_rt_val = 32'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_done = 0;
    pending = 1'b0;
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_ops_done", {16'h0, ops_done}, 32'd0);
    step();
    check("mid_rst_no_result", {31'b0, out_valid}, 32'd0);

    // Randomized ops with random stalls and back-to-back retire/accept
    for (int k = 0; k < 80; k++) begin
      logic [5:0]  opc, fn;
      logic [31:0] rs, rt;
      opc = op_tab[$urandom_range(0, 11)];
      fn  = fn_tab[$urandom_range(0, 11)];
      rs  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      rt  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      if (pending) begin
        hold_done($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) retire(0);
      end
      send(opc, fn, rs, rt, 16'($urandom));
    end
    if (pending) retire(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
